// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified instruction/data memory between the
// instruction-fetch port (IF) and the load/store data port (DM) of a
// non-pipelined RISC-V core. Round-robin arbitration, variable-latency
// memory handshake, one-cycle acknowledge to the granted requester.
//
// Ports:
//   clk, reset         clock (rising edge) and asynchronous active-low reset
//   if_req/if_addr     fetch request and address
//   if_rdata/if_ack    fetched word and one-cycle completion pulse
//   dm_req/dm_we       data request and store select (1=store, 0=load)
//   dm_addr/dm_wdata   data address and store data
//   dm_rdata/dm_ack    load data and one-cycle completion pulse
//   mem_en/mem_we      memory access strobe and write enable
//   mem_addr/mem_wdata memory address and write data
//   mem_rdata/mem_ready memory read data and completion
//   owner              current/last grant (0=IF, 1=DM)
//   busy               high while a transaction is in ACCESS or RESP
//   err                sticky timeout flag
//
// Optional feature: define ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT
// cycles without mem_ready, returning 32'hDEADBEEF and setting err.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              grant_dm;
    logic              mem_en_next, mem_we_next, owner_next, busy_next;
    logic              if_ack_next, dm_ack_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next, if_rdata_next, dm_rdata_next;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_next;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the values the outputs take in the following cycle.
    // The memory-side registers double as the latched request registers.
    always_comb begin
        state_next     = state;
        grant_dm       = 1'b0;
        mem_en_next    = 1'b0;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;
        if_rdata_next  = if_rdata;
        dm_rdata_next  = dm_rdata;
        owner_next     = owner;
`ifdef ARB_TIMEOUT_EN
        cnt_next       = cnt;
        err_next       = err;
`endif
        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    // Under contention the port that did not win last time goes
                    grant_dm = dm_req && (!if_req || !owner);
                    owner_next = grant_dm;
                    if (grant_dm) begin
                        mem_we_next    = dm_we;
                        mem_addr_next  = dm_addr;
                        mem_wdata_next = dm_wdata;
                    end else begin
                        mem_we_next    = 1'b0;
                        mem_addr_next  = if_addr;
                        mem_wdata_next = '0;
                    end
                    mem_en_next = 1'b1;
                    state_next  = ACCESS;
`ifdef ARB_TIMEOUT_EN
                    cnt_next    = '0;
`endif
                end
            end
            ACCESS: begin
                mem_en_next = 1'b1;
                // mem_ready wins over a timeout landing in the same cycle
                if (mem_ready) begin
                    mem_en_next = 1'b0;
                    state_next  = RESP;
                    if (owner) begin
                        dm_rdata_next = mem_rdata;
                        dm_ack_next   = 1'b1;
                    end else begin
                        if_rdata_next = mem_rdata;
                        if_ack_next   = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    mem_en_next = 1'b0;
                    state_next  = RESP;
                    err_next    = 1'b1;
                    if (owner) begin
                        dm_rdata_next = DATA_W'(32'hDEADBEEF);
                        dm_ack_next   = 1'b1;
                    end else begin
                        if_rdata_next = DATA_W'(32'hDEADBEEF);
                        if_ack_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset mid-transaction drops it silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            owner     <= 1'b1;
            busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            if_ack    <= if_ack_next;
            dm_ack    <= dm_ack_next;
            if_rdata  <= if_rdata_next;
            dm_rdata  <= dm_rdata_next;
            owner     <= owner_next;
            busy      <= busy_next;
`ifdef ARB_TIMEOUT_EN
            cnt       <= cnt_next;
            err       <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: single fetch, round-robin contention,
// wait-stated store, asynchronous reset mid-access, and the ARB_TIMEOUT_EN
// (or indefinite-wait) behaviour. Inputs change and outputs are sampled on
// the falling clock edge.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        owner;
    logic        busy;
    logic        err;

    int compared;
    int mismatched;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .owner    (owner),
        .busy     (busy),
        .err      (err)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives every requester and memory input at once
    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic d_req, input logic d_we,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                 input logic m_ready, input logic [31:0] m_rdata);
        if_req    = i_req;
        if_addr   = i_addr;
        dm_req    = d_req;
        dm_we     = d_we;
        dm_addr   = d_addr;
        dm_wdata  = d_wdata;
        mem_ready = m_ready;
        mem_rdata = m_rdata;
    endtask

    // One comparison: counts it, and on a difference counts and reports it
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_if_ack", if_ack, 0);
        checkOutput("rst_dm_ack", dm_ack, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_dm_rdata", dm_rdata, 0);
        checkOutput("rst_owner", owner, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);

        // Single zero-wait fetch: ACCESS in cycle 1, ack in cycle 2
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 1, 32'h00500093);
        @(negedge clk);
        checkOutput("f_c1_mem_en", mem_en, 1);
        checkOutput("f_c1_mem_addr", mem_addr, 32'h10);
        checkOutput("f_c1_mem_we", mem_we, 0);
        checkOutput("f_c1_busy", busy, 1);
        checkOutput("f_c1_if_ack", if_ack, 0);
        @(negedge clk);
        checkOutput("f_c2_if_ack", if_ack, 1);
        checkOutput("f_c2_if_rdata", if_rdata, 32'h00500093);
        checkOutput("f_c2_busy", busy, 1);
        checkOutput("f_c2_mem_en", mem_en, 0);
        checkOutput("f_c2_dm_ack", dm_ack, 0);
        checkOutput("f_c2_owner", owner, 0);
        applyStimulus(0, 32'h10, 0, 0, 0, 0, 1, 32'h00500093);
        @(negedge clk);
        checkOutput("f_c3_if_ack", if_ack, 0);
        checkOutput("f_c3_busy", busy, 0);

        // Continuous contention after reset: IF, DM, IF, DM
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("rr_rst_owner", owner, 1);
        applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h1000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rr_owner", owner, k[0]);
            checkOutput("rr_mem_en", mem_en, 1);
            checkOutput("rr_mem_addr", mem_addr, k[0] ? 32'h200 : 32'h100);
            mem_rdata = 32'h1000 + k;
            @(negedge clk);
            checkOutput("rr_if_ack", if_ack, !k[0]);
            checkOutput("rr_dm_ack", dm_ack, k[0]);
            if (k[0])
                checkOutput("rr_dm_rdata", dm_rdata, 32'h1000 + k);
            else
                checkOutput("rr_if_rdata", if_rdata, 32'h1000 + k);
            if (k == 3) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            @(negedge clk);
            checkOutput("rr_idle_busy", busy, 0);
            checkOutput("rr_idle_mem_en", mem_en, 0);
        end

        // Store with four wait cycles; latched request must stay stable
        applyStimulus(0, 0, 1, 1, 32'h40, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("st_mem_en", mem_en, 1);
            checkOutput("st_mem_we", mem_we, 1);
            checkOutput("st_mem_addr", mem_addr, 32'h40);
            checkOutput("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
            checkOutput("st_dm_ack", dm_ack, 0);
            checkOutput("st_if_ack", if_ack, 0);
            dm_addr  = 32'hFFFFFFF0;
            dm_wdata = 32'h0;
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h12345678;
            end
            @(negedge clk);
        end
        checkOutput("st_resp_dm_ack", dm_ack, 1);
        checkOutput("st_resp_dm_rdata", dm_rdata, 32'h12345678);
        checkOutput("st_resp_if_ack", if_ack, 0);
        checkOutput("st_resp_if_rdata", if_rdata, 32'h1002);
        checkOutput("st_resp_owner", owner, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("st_idle_dm_ack", dm_ack, 0);
        checkOutput("st_idle_busy", busy, 0);

        // Asynchronous reset while in ACCESS
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ar_pre_mem_en", mem_en, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_mem_en", mem_en, 0);
        checkOutput("ar_if_ack", if_ack, 0);
        checkOutput("ar_dm_ack", dm_ack, 0);
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_mem_addr", mem_addr, 0);
        checkOutput("ar_owner", owner, 1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ar_post_if_ack", if_ack, 0);
            checkOutput("ar_post_mem_en", mem_en, 0);
        end
        applyStimulus(1, 32'h84, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
        @(negedge clk);
        checkOutput("ar_new_mem_addr", mem_addr, 32'h84);
        @(negedge clk);
        checkOutput("ar_new_if_ack", if_ack, 1);
        checkOutput("ar_new_if_rdata", if_rdata, 32'hA5A5A5A5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort after 15 ACCESS cycles
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 32'h77);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            checkOutput("to_mem_en", mem_en, 1);
            checkOutput("to_dm_ack", dm_ack, 0);
            checkOutput("to_err_before", err, 0);
            @(negedge clk);
        end
        checkOutput("to_dm_ack_pulse", dm_ack, 1);
        checkOutput("to_dm_rdata", dm_rdata, 32'hDEADBEEF);
        checkOutput("to_err_set", err, 1);
        dm_req = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        dm_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("to_good_dm_ack", dm_ack, 1);
        checkOutput("to_good_dm_rdata", dm_rdata, 32'h77);
        checkOutput("to_good_err", err, 1);
        dm_req = 1'b0;
        @(negedge clk);
        checkOutput("to_err_sticky", err, 1);
`else
        // Memory never answers: ACCESS waits indefinitely
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 32'h77);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            checkOutput("nt_dm_ack", dm_ack, 0);
            @(negedge clk);
        end
        checkOutput("nt_mem_en", mem_en, 1);
        checkOutput("nt_busy", busy, 1);
        checkOutput("nt_err", err, 0);
        reset = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port memory between two requesters of the non-pipelined RISC-V core:
  - the instruction-fetch port (IF);
  - the load/store data port (DM).
- Sits between the core's fetch/LSU logic and the unified instruction/data memory.
- Round-robin arbitration, variable-latency memory handshake, one-cycle acknowledge per requester; the core stalls on the requester's pending request until its ack.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max ACCESS cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held high until if_ack
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched word; valid while if_ack=1
- if_ack  output  1  one-cycle fetch completion pulse
- dm_req  input  1  data request; held high until dm_ack
- dm_we  input  1  1=store, 0=load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data; valid while dm_ack=1
- dm_ack  output  1  one-cycle data completion pulse
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data; valid with mem_ready
- mem_ready  input  1  memory completion; sampled only in ACCESS
- owner  output  1  0=IF, 1=DM; current/last grant
- busy  output  1  high in ACCESS or RESP
- err  output  1  sticky timeout flag

## Operation

- FSM states:
  - IDLE: mem_en=0, acks=0.
    - No request: stay.
    - One request: grant it.
    - Both requests: grant the requester opposite to owner.
    - On grant: latch addr/we/wdata into registers, set owner, go ACCESS.
  - ACCESS: mem_en=1; mem_we/addr/wdata driven from latched registers.
    - Requester inputs are ignored while in ACCESS.
    - mem_ready=1: capture mem_rdata into the granted requester's rdata register, go RESP.
  - RESP: granted requester's ack=1 for exactly one cycle, then go IDLE.
    - dm_rdata is updated on stores too (captures mem_rdata).
- The non-granted requester's rdata register holds its old value.
- Requester sees ack at the end of RESP and updates req at the same edge. IDLE therefore samples the requester's next request, so a held req is a new transaction.
- Round-robin: owner alternates under continuous contention, so neither port starves. A lone requester is granted repeatedly.
- Reset (async, reset=0):
  - state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
  - owner=1, so IF wins the first contention; busy=0; err=0.
  - Reset mid-ACCESS/RESP drops the transaction with no ack.
- Simultaneous mem_ready and a new request in ACCESS: the request is not considered until IDLE.

## Timing

- All outputs registered.
- Minimum transaction: 3 cycles.
  - Cycle 0: IDLE samples req.
  - Cycle 1: ACCESS with mem_ready=1.
  - Cycle 2: RESP, ack.
- Each extra cycle of mem_ready=0 in ACCESS adds one cycle.
- Back-to-back throughput: one transaction per 3 cycles with zero-wait memory.
- busy=1 exactly in the ACCESS and RESP cycles.

## Configuration

- Macro ARB_TIMEOUT_EN:
  - Defined:
    - A 4-bit-or-wider cycle counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
    - When it reaches TIMEOUT, go RESP and return rdata=32'hDEADBEEF with ack.
    - err is set and stays set until reset.
    - mem_ready arriving in the same cycle as the timeout takes precedence: normal data, err unchanged.
  - Not defined: ACCESS waits indefinitely; err is tied to 0; no counter logic.

## Test plan

- Reset, then if_req=1, if_addr=0x10, mem_ready always 1, mem_rdata=0x00500093:
  - mem_en high in cycle 1 with mem_addr=0x10;
  - if_ack pulses in cycle 2 with if_rdata=0x00500093;
  - busy high in cycles 1-2.
- if_req and dm_req asserted together and held continuously:
  - grants alternate IF, DM, IF, DM (first is IF after reset);
  - owner toggles every 3 cycles.
- Store dm_we=1, dm_addr=0x40, dm_wdata=0xCAFEF00D, mem_ready delayed 4 cycles:
  - mem_we=1, mem_addr/mem_wdata stable through all 5 ACCESS cycles;
  - dm_ack on the following cycle;
  - if_ack stays 0.
- Assert reset low during ACCESS:
  - mem_en and all acks drop immediately (asynchronous);
  - no ack after release;
  - a new if_req completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0:
  - dm_ack after 15 ACCESS cycles with dm_rdata=0xDEADBEEF;
  - err=1 and stays 1 through subsequent good transactions.
- Without ARB_TIMEOUT_EN, mem_ready held 0 for 100 cycles: still in ACCESS, no ack, err=0.
